// File: rtl/buffer_pkgs.sv
// Shared result-bus types for the execute -> writeback boundary.
// Holds FU result packets, the CDB packet and source indices.
package buffer_pkgs;

  localparam int ROB_TAG_W = 5;
  localparam int PRD_W     = 6;
  localparam int XLEN      = 32;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_BR  = 2'd1;
  localparam logic [1:0] SRC_LSU = 2'd2;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [PRD_W-1:0]     prd;
    logic                 rd_we;
    logic [XLEN-1:0]      result;
  } alu_out_t;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [PRD_W-1:0]     prd;
    logic                 rd_we;
    logic [XLEN-1:0]      result;
    logic                 mispredict;
    logic [XLEN-1:0]      target_pc;
  } branch_out_t;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [PRD_W-1:0]     prd;
    logic                 rd_we;
    logic [XLEN-1:0]      result;
  } lsu_out_t;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [PRD_W-1:0]     prd;
    logic                 rd_we;
    logic [XLEN-1:0]      result;
    logic [1:0]           src;
  } cdb_t;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: combinational grant, registered pointer.
// Pointer moves just past the granted source; it holds when idle.
module rr_arbiter3
  import buffer_pkgs::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [2:0] req_i,
  output logic [2:0] gnt_o,
  output logic [1:0] ptr_o
);

  logic [1:0] ptr_q, ptr_d, base;

  // Encoding 3 is never produced; decode it as 0 if it appears.
  assign base  = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
  assign ptr_o = ptr_q;

  always_comb begin
    logic [2:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    gnt_o = '0;
    for (int i = 0; i < 3; i++) begin
      idx = {1'b0, base} + 3'(i);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!found && req_i[idx[1:0]]) begin
        gnt_o[idx[1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = base;
    unique case (1'b1)
      gnt_o[0]: ptr_d = SRC_BR;
      gnt_o[1]: ptr_d = SRC_LSU;
      gnt_o[2]: ptr_d = SRC_ALU;
      default:  ptr_d = base;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= 2'd0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: round-robin pick of ALU/BR/LSU results onto the CDB,
// plus a registered redirect pulse for mispredicted branches.
module writeback_arbiter
  import buffer_pkgs::*;
#(
  parameter type AO = alu_out_t,
  parameter type BO = branch_out_t,
  parameter type LO = lsu_out_t,
  parameter type CO = cdb_t
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic                 alu_valid_i,
  output logic                 alu_ready_o,
  input  AO                    alu_data_i,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  BO                    b_data_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  LO                    lsu_data_i,
  output logic                 cdb_valid_o,
  output CO                    cdb_data_o,
  output logic                 redirect_valid_o,
  output logic [XLEN-1:0]      redirect_pc_o,
  output logic [ROB_TAG_W-1:0] redirect_rob_tag_o
);

  logic [2:0] req, gnt;
  logic [1:0] ptr_unused;
  CO          pkt_d;
  logic       redir_d;

  logic                 cdb_valid_q;
  CO                    cdb_data_q;
  logic                 redir_valid_q;
  logic [XLEN-1:0]      redir_pc_q;
  logic [ROB_TAG_W-1:0] redir_tag_q;

  assign req = {lsu_valid_i, b_valid_i, alu_valid_i}
             & {3{~reset_i & ~flush_i}};

  rr_arbiter3 u_arb (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .req_i  (req),
    .gnt_o  (gnt),
    .ptr_o  (ptr_unused)
  );

  assign alu_ready_o = gnt[0];
  assign b_ready_o   = gnt[1];
  assign lsu_ready_o = gnt[2];

  assign redir_d = gnt[1] & b_data_i.mispredict;

  always_comb begin
    pkt_d = '0;
    unique case (1'b1)
      gnt[1]: begin
        pkt_d.rob_tag = b_data_i.rob_tag;
        pkt_d.prd     = b_data_i.prd;
        pkt_d.rd_we   = b_data_i.rd_we;
        pkt_d.result  = b_data_i.result;
        pkt_d.src     = SRC_BR;
      end
      gnt[2]: begin
        pkt_d.rob_tag = lsu_data_i.rob_tag;
        pkt_d.prd     = lsu_data_i.prd;
        pkt_d.rd_we   = lsu_data_i.rd_we;
        pkt_d.result  = lsu_data_i.result;
        pkt_d.src     = SRC_LSU;
      end
      default: begin
        pkt_d.rob_tag = alu_data_i.rob_tag;
        pkt_d.prd     = alu_data_i.prd;
        pkt_d.rd_we   = alu_data_i.rd_we;
        pkt_d.result  = alu_data_i.result;
        pkt_d.src     = SRC_ALU;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cdb_valid_q   <= 1'b0;
      cdb_data_q    <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      redir_tag_q   <= '0;
    end else begin
      cdb_valid_q   <= |gnt;
      redir_valid_q <= redir_d;
      if (|gnt) cdb_data_q <= pkt_d;
      if (redir_d) begin
        redir_pc_q  <= b_data_i.target_pc;
        redir_tag_q <= b_data_i.rob_tag;
      end
    end
  end

  assign cdb_valid_o        = cdb_valid_q;
  assign cdb_data_o         = cdb_data_q;
  assign redirect_valid_o   = redir_valid_q;
  assign redirect_pc_o      = redir_pc_q;
  assign redirect_rob_tag_o = redir_tag_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios, then random traffic
// checked against a cycle-level round-robin reference model.
module tb_writeback_arbiter;
  import buffer_pkgs::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        av, bv, lv;
  logic        ar, br, lr;
  alu_out_t    ad;
  branch_out_t bd;
  lsu_out_t    ld;
  logic        cv;
  cdb_t        cd;
  logic        rv;
  logic [31:0] rpc;
  logic [4:0]  rtag;

  int total = 0;
  int bad   = 0;

  int          m_ptr;
  logic        m_cv, m_rv;
  cdb_t        m_cd;
  logic [31:0] m_rpc;
  logic [4:0]  m_rtag;

  always #5 clk = ~clk;

  writeback_arbiter dut (
    .clk_i(clk), .reset_i(rst), .flush_i(flush),
    .alu_valid_i(av), .alu_ready_o(ar), .alu_data_i(ad),
    .b_valid_i(bv), .b_ready_o(br), .b_data_i(bd),
    .lsu_valid_i(lv), .lsu_ready_o(lr), .lsu_data_i(ld),
    .cdb_valid_o(cv), .cdb_data_o(cd),
    .redirect_valid_o(rv), .redirect_pc_o(rpc),
    .redirect_rob_tag_o(rtag)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Winner under the rule: scan ptr, ptr+1, ptr+2 (mod 3); -1 if none.
  function automatic int winner();
    logic [2:0] v;
    v = {lv, bv, av};
    if (rst || flush) return -1;
    for (int k = 0; k < 3; k++)
      if (v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    return -1;
  endfunction

  // Inputs are set; check readies, clock once, then check outputs.
  task automatic cycle();
    int w;
    logic [2:0] exp_rdy;
    cdb_t nxt;
    w = winner();
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    #1;
    check("ready", 64'({lr, br, ar}), 64'(exp_rdy));
    nxt = m_cd;
    if (w == 0) nxt = '{ad.rob_tag, ad.prd, ad.rd_we, ad.result, 2'd0};
    if (w == 1) nxt = '{bd.rob_tag, bd.prd, bd.rd_we, bd.result, 2'd1};
    if (w == 2) nxt = '{ld.rob_tag, ld.prd, ld.rd_we, ld.result, 2'd2};
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_cv = 0; m_cd = '0; m_rv = 0; m_rpc = '0; m_rtag = '0;
    end else begin
      m_cv = (w >= 0);
      m_cd = nxt;
      m_rv = (w == 1) && bd.mispredict;
      if (m_rv) begin
        m_rpc  = bd.target_pc;
        m_rtag = bd.rob_tag;
      end
      if (w >= 0) m_ptr = (w + 1) % 3;
    end
    #1;
    check("cdb_valid", 64'(cv), 64'(m_cv));
    check("cdb_data", 64'(cd), 64'(m_cd));
    check("redir_valid", 64'(rv), 64'(m_rv));
    check("redir_pc", 64'(rpc), 64'(m_rpc));
    check("redir_tag", 64'(rtag), 64'(m_rtag));
    check("rr_ptr", 64'(dut.u_arb.ptr_q), 64'(m_ptr));
  endtask

  task automatic rand_data();
    ad.rob_tag = 5'($urandom); ad.prd = 6'($urandom);
    ad.rd_we = 1'($urandom); ad.result = $urandom;
    bd.rob_tag = 5'($urandom); bd.prd = 6'($urandom);
    bd.rd_we = 1'($urandom); bd.result = $urandom;
    bd.mispredict = 1'($urandom); bd.target_pc = $urandom;
    ld.rob_tag = 5'($urandom); ld.prd = 6'($urandom);
    ld.rd_we = 1'($urandom); ld.result = $urandom;
  endtask

  task automatic set_v(input logic a, input logic b, input logic l);
    av = a; bv = b; lv = l;
  endtask

  initial begin
    m_ptr = 0; m_cv = 0; m_cd = '0; m_rv = 0; m_rpc = '0; m_rtag = '0;
    rst = 1; flush = 0;
    set_v(0, 0, 0);
    rand_data();
    bd.mispredict = 0;
    @(posedge clk);
    cycle();
    cycle();
    rst = 0;

    // ALU alone
    ad.result = 32'h1234; ad.prd = 6'd5;
    set_v(1, 0, 0);
    cycle();
    check("alu_result", 64'(cd.result), 64'h1234);
    check("alu_src", 64'(cd.src), 64'd0);
    set_v(0, 0, 0);
    cycle();

    // All three valid from reset
    rst = 1; cycle(); rst = 0;
    bd.mispredict = 0;
    set_v(1, 1, 1);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("rr_order", 64'(cd.src), 64'(i % 3));
    end

    // Mispredicted branch
    set_v(0, 1, 0);
    bd.mispredict = 1; bd.target_pc = 32'h8000_0040; bd.rob_tag = 5'd7;
    cycle();
    check("mp_pc", 64'(rpc), 64'h8000_0040);
    check("mp_tag", 64'(rtag), 64'd7);
    set_v(0, 0, 0);
    cycle();

    // Flush with everything valid, then resume
    set_v(1, 1, 1);
    bd.mispredict = 0;
    flush = 1; cycle(); cycle();
    flush = 0; cycle(); cycle();

    // Wrap-around: get ptr to 2, then ALU+BR
    set_v(0, 1, 0); cycle();
    set_v(1, 1, 0); cycle();
    check("wrap_src", 64'(cd.src), 64'd0);

    // Reset during active CDB and redirect
    set_v(0, 1, 0); bd.mispredict = 1; cycle();
    set_v(1, 1, 1);
    rst = 1; flush = 1; cycle(); cycle();
    rst = 0; flush = 0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_data();
      set_v(1'($urandom), 1'($urandom), 1'($urandom));
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
